// File: rtl/mult_sequencer_if.sv
// Bundle between the execute/write-back side, the multiplier array and mult_sequencer.
// The sequencer uses the slave view; the surrounding logic uses the master view.
interface mult_sequencer_if;
  localparam int unsigned AW = 32;
  localparam int unsigned BW = 16;
  localparam int unsigned TW = 5;

  logic          ctrl_MULT;
  logic [AW-1:0] data_operandA;
  logic [BW-1:0] data_operandB;
  logic [TW-1:0] ctrl_tag;
  logic          ctrl_ack;
  logic [AW-1:0] mult_operandA;
  logic [BW-1:0] mult_operandB;
  logic [AW-1:0] mult_result;
  logic          mult_exception;
  logic [AW-1:0] data_result;
  logic          data_exception;
  logic [TW-1:0] data_tag;
  logic          data_inputRDY;
  logic          data_resultRDY;
  logic          data_dropped;

  modport master (
    output ctrl_MULT, data_operandA, data_operandB, ctrl_tag, ctrl_ack,
           mult_result, mult_exception,
    input  mult_operandA, mult_operandB, data_result, data_exception, data_tag,
           data_inputRDY, data_resultRDY, data_dropped
  );

  modport slave (
    input  ctrl_MULT, data_operandA, data_operandB, ctrl_tag, ctrl_ack,
           mult_result, mult_exception,
    output mult_operandA, mult_operandB, data_result, data_exception, data_tag,
           data_inputRDY, data_resultRDY, data_dropped
  );
endinterface

// File: rtl/mult_sequencer.sv
// Issue/capture controller around the combinational Booth multiplier array:
// holds operands for LATENCY cycles, then captures the product behind a ready/ack handshake.
module mult_sequencer #(
  parameter int unsigned LATENCY = 3
) (
  input logic             clock,
  input logic             reset,
  mult_sequencer_if.slave bus
);
  localparam int unsigned AW = 32;
  localparam int unsigned BW = 16;
  localparam int unsigned TW = 5;
  localparam int unsigned CW = 3;
  localparam logic [CW-1:0] LAST = CW'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [AW-1:0] opa_q;
  logic [BW-1:0] opb_q;
  logic [TW-1:0] tag_q;
  logic          opzero_q;
  logic [AW-1:0] result_q;
  logic          exc_q;
  logic [TW-1:0] res_tag_q;
  logic          inrdy_q;
  logic          resrdy_q;
  logic          dropped_q;

  // Ready flags are flopped alongside the state so they never see an input path.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      tag_q     <= '0;
      opzero_q  <= 1'b0;
      result_q  <= '0;
      exc_q     <= 1'b0;
      res_tag_q <= '0;
      inrdy_q   <= 1'b1;
      resrdy_q  <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      dropped_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.ctrl_MULT) begin
            opa_q    <= bus.data_operandA;
            opb_q    <= bus.data_operandB;
            tag_q    <= bus.ctrl_tag;
            opzero_q <= (bus.data_operandA == '0) | (bus.data_operandB == '0);
            cnt_q    <= '0;
            state_q  <= BUSY;
            inrdy_q  <= 1'b0;
          end
        end
        BUSY: begin
          dropped_q <= bus.ctrl_MULT;
          cnt_q     <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            result_q  <= bus.mult_result;
            // Raw flag misfires on a zero product with a negative operand.
            exc_q     <= bus.mult_exception & ~opzero_q;
            res_tag_q <= tag_q;
            state_q   <= DONE;
            resrdy_q  <= 1'b1;
          end
        end
        DONE: begin
          dropped_q <= bus.ctrl_MULT;
          if (bus.ctrl_ack) begin
            state_q  <= IDLE;
            resrdy_q <= 1'b0;
            inrdy_q  <= 1'b1;
          end
        end
        default: begin
          state_q  <= IDLE;
          inrdy_q  <= 1'b1;
          resrdy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mult_operandA  = opa_q;
  assign bus.mult_operandB  = opb_q;
  assign bus.data_result    = result_q;
  assign bus.data_exception = exc_q;
  assign bus.data_tag       = res_tag_q;
  assign bus.data_inputRDY  = inrdy_q;
  assign bus.data_resultRDY = resrdy_q;
  assign bus.data_dropped   = dropped_q;
endmodule

// File: tb/tb_mult_sequencer.sv
// Self-checking bench for mult_sequencer: directed plan steps plus randomized operations
// checked against an arithmetic model of the multiplier and the issue/capture timing.
module tb_mult_sequencer;
  localparam int unsigned LAT = 3;

  logic clock = 1'b0;
  logic reset;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  mult_sequencer_if bus();

  mult_sequencer #(.LATENCY(LAT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Model of the multiplier array: true 48-bit product truncated to 32 bits.
  function automatic longint full_prod(input logic [31:0] a, input logic [15:0] b);
    return longint'($signed(a)) * longint'($signed(b));
  endfunction

  function automatic logic [31:0] ref_prod(input logic [31:0] a, input logic [15:0] b);
    logic [63:0] p;
    p = 64'(full_prod(a, b));
    return p[31:0];
  endfunction

  // Raw flag: overflow, or result sign disagrees with the operand sign rule.
  function automatic logic ref_raw(input logic [31:0] a, input logic [15:0] b);
    longint      p;
    logic [31:0] r;
    p = full_prod(a, b);
    r = ref_prod(a, b);
    return (p != longint'($signed(r))) || (r[31] != (a[31] ^ b[15]));
  endfunction

  always_comb begin
    bus.mult_result    = ref_prod(bus.mult_operandA, bus.mult_operandB);
    bus.mult_exception = ref_raw(bus.mult_operandA, bus.mult_operandB);
  end

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One full operation; drop_at pulses ctrl_MULT during BUSY cycle index drop_at.
  task automatic do_op(input logic [31:0] a, input logic [15:0] b, input logic [4:0] tag,
                       input int ack_delay, input int drop_at, input bit ack_pre,
                       input bit mult_on_ack, output int acc_cyc);
    int          waited;
    logic [31:0] er;
    logic        ee;
    waited  = 0;
    acc_cyc = 0;
    er = ref_prod(a, b);
    ee = ref_raw(a, b) & ~((a == 32'd0) | (b == 16'd0));
    while (bus.data_inputRDY !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    if (bus.data_inputRDY !== 1'b1) begin
      check("wait_inputRDY", 64'(bus.data_inputRDY), 64'd1);
      return;
    end
    bus.ctrl_ack      = ack_pre;
    bus.ctrl_MULT     = 1'b1;
    bus.data_operandA = a;
    bus.data_operandB = b;
    bus.ctrl_tag      = tag;
    tick();
    acc_cyc = cyc;
    bus.ctrl_MULT     = 1'b0;
    bus.data_operandA = $urandom;
    bus.data_operandB = 16'($urandom);
    bus.ctrl_tag      = 5'($urandom);
    check("accept_inputRDY", 64'(bus.data_inputRDY), 64'd0);
    for (int k = 0; k < int'(LAT); k++) begin
      check("opA_hold", 64'(bus.mult_operandA), 64'(a));
      check("opB_hold", 64'(bus.mult_operandB), 64'(b));
      check("busy_resultRDY", 64'(bus.data_resultRDY), 64'd0);
      if (k == drop_at) begin
        bus.ctrl_MULT     = 1'b1;
        bus.data_operandA = 32'd9;
      end
      tick();
      bus.ctrl_MULT = 1'b0;
      check("busy_dropped", 64'(bus.data_dropped), 64'(k == drop_at));
    end
    check("cap_resultRDY", 64'(bus.data_resultRDY), 64'd1);
    check("cap_result", 64'(bus.data_result), 64'(er));
    check("cap_exception", 64'(bus.data_exception), 64'(ee));
    check("cap_tag", 64'(bus.data_tag), 64'(tag));
    check("cap_inputRDY", 64'(bus.data_inputRDY), 64'd0);
    for (int d = 0; d < ack_delay; d++) begin
      tick();
      check("done_hold_rdy", 64'(bus.data_resultRDY), 64'd1);
      check("done_hold_res", 64'(bus.data_result), 64'(er));
      check("done_dropped", 64'(bus.data_dropped), 64'd0);
    end
    bus.ctrl_ack  = 1'b1;
    bus.ctrl_MULT = mult_on_ack;
    tick();
    bus.ctrl_MULT = 1'b0;
    bus.ctrl_ack  = ack_pre;
    check("ack_resultRDY", 64'(bus.data_resultRDY), 64'd0);
    check("ack_inputRDY", 64'(bus.data_inputRDY), 64'd1);
    check("ack_dropped", 64'(bus.data_dropped), 64'(mult_on_ack));
    check("ack_result_kept", 64'(bus.data_result), 64'(er));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int          c1, c2, c;
    logic [31:0] ra;
    logic [15:0] rb;
    int          mode;

    // Reset with a request pending.
    reset             = 1'b1;
    bus.ctrl_MULT     = 1'b1;
    bus.ctrl_ack      = 1'b0;
    bus.data_operandA = 32'h1234_5678;
    bus.data_operandB = 16'h4321;
    bus.ctrl_tag      = 5'd17;
    tick();
    tick();
    check("rst_inputRDY", 64'(bus.data_inputRDY), 64'd1);
    check("rst_resultRDY", 64'(bus.data_resultRDY), 64'd0);
    check("rst_result", 64'(bus.data_result), 64'd0);
    check("rst_exception", 64'(bus.data_exception), 64'd0);
    check("rst_tag", 64'(bus.data_tag), 64'd0);
    check("rst_opA", 64'(bus.mult_operandA), 64'd0);
    check("rst_opB", 64'(bus.mult_operandB), 64'd0);
    check("rst_dropped", 64'(bus.data_dropped), 64'd0);
    bus.ctrl_MULT = 1'b0;
    reset         = 1'b0;
    tick();

    // Basic multiply 7 * -3.
    do_op(32'd7, 16'hFFFD, 5'd5, 2, -1, 1'b0, 1'b0, c);
    check("basic_result", 64'(bus.data_result), 64'hFFFF_FFEB);
    check("basic_tag", 64'(bus.data_tag), 64'd5);

    // Zero masking and true overflow.
    do_op(32'h8000_0000, 16'd0, 5'd1, 0, -1, 1'b0, 1'b0, c);
    check("zero_mask_exc", 64'(bus.data_exception), 64'd0);
    do_op(32'h4000_0000, 16'd4, 5'd2, 1, -1, 1'b0, 1'b0, c);
    check("overflow_exc", 64'(bus.data_exception), 64'd1);

    // Request while busy is dropped without disturbing the operation.
    do_op(32'd100, 16'd3, 5'd9, 1, 0, 1'b0, 1'b0, c);
    check("busy_rej_result", 64'(bus.data_result), 64'd300);

    // Reset in the middle of BUSY discards the operation.
    bus.ctrl_MULT     = 1'b1;
    bus.data_operandA = 32'd11;
    bus.data_operandB = 16'd13;
    bus.ctrl_tag      = 5'd3;
    tick();
    bus.ctrl_MULT = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_inputRDY", 64'(bus.data_inputRDY), 64'd1);
    check("midrst_result", 64'(bus.data_result), 64'd0);
    check("midrst_opA", 64'(bus.mult_operandA), 64'd0);
    for (int i = 0; i < int'(LAT) + 1; i++) begin
      tick();
      check("midrst_no_result", 64'(bus.data_resultRDY), 64'd0);
    end
    do_op(32'd2, 16'd3, 5'd4, 0, -1, 1'b0, 1'b0, c);
    check("after_rst_result", 64'(bus.data_result), 64'd6);

    // Back-to-back with ack tied high.
    do_op(32'd3, 16'd4, 5'd6, 0, -1, 1'b1, 1'b0, c1);
    check("b2b_first", 64'(bus.data_result), 64'd12);
    do_op(32'hFFFF_FFFB, 16'd6, 5'd7, 0, -1, 1'b1, 1'b0, c2);
    check("b2b_second", 64'(bus.data_result), 64'hFFFF_FFE2);
    check("b2b_interval", 64'(c2 - c1), 64'(LAT + 2));
    bus.ctrl_ack = 1'b0;

    // Randomized operations with random ack delays, busy drops and ack+request collisions.
    for (int i = 0; i < 24; i++) begin
      ra   = $urandom;
      rb   = 16'($urandom);
      mode = int'($urandom_range(0, 4));
      if (mode == 0) ra = 32'd0;
      if (mode == 1) rb = 16'd0;
      if (mode == 2) ra = 32'($signed(16'($urandom)));
      do_op(ra, rb, 5'($urandom), int'($urandom_range(0, 3)),
            int'($urandom_range(0, LAT)) - 1, 1'b0, 1'($urandom_range(0, 1)), c);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
